gen_fip_sign_extremum_finder: RTL and testbench
===============================================

Name: gen_fip_sign_extremum_finder

Overview:
- Sequential successor to the single-shot signed fixed-point comparator.
- After a start pulse, accepts a stream of NUM_ELEMS signed two's-complement fixed-point samples. Tracks the running maximum or minimum (runtime mode) and its index.
- Reports the extremum value and index with a done pulse.
- Used by fitness/selection stages that must pick the best of N candidates without a comparator tree.

Parameters:
- INT_W, 2, integer width including sign bit.
- FRACT_W, 4, fraction width.
- NUM_ELEMS, 4, samples per search; legal range 2..65536.
- W (local, do not override), INT_W+FRACT_W, sample width.
- IDX_W (local, do not override), max(1,$clog2(NUM_ELEMS)), index width.

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- i_start_pls  in  1  one-cycle pulse that begins a search.
- i_mode  in  1  0=find max, 1=find min; sampled only on an accepted start.
- i_valid  in  1  i_num carries a sample this cycle.
- i_num  in  W  signed fixed-point sample.
- o_busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive.
- o_done_pls  out  1  one-cycle pulse; results valid from this cycle.
- o_ext_num  out  W  extremum value.
- o_ext_idx  out  IDX_W  zero-based arrival index of the extremum.

Behaviour:
- Reset (rstn=0 at posedge) forces all outputs, the counter and the mode register to 0 and the state to IDLE. This includes reset mid-search: the partial result is discarded and no done pulse is issued.
- States:
  - IDLE: i_start_pls=1 latches i_mode, clears the counter and goes to COLLECT. i_valid in IDLE is ignored.
  - COLLECT: each cycle with i_valid=1 is one accepted sample with index = counter. After the sample with index NUM_ELEMS-1 the next state is DONE. i_valid=0 stalls with no timeout.
  - DONE: o_done_pls=1 for exactly one cycle, o_busy=1, then IDLE.
- A sample presented in the same cycle as the accepted start is NOT taken; the first sample is taken at the earliest the cycle after start.
- i_start_pls while in COLLECT or DONE is ignored: no restart, no mode change.
- Comparison rules:
  - Signed two's-complement compare on the full W bits. The most negative code (1 followed by zeros) must order correctly as the smallest value; do not use an abs-based method.
  - Sample 0 is loaded unconditionally into the extremum register.
  - For later samples, update only when strictly greater (max mode) or strictly less (min mode). Ties keep the earliest index.
- Result registers:
  - o_ext_num and o_ext_idx are driven from the running registers.
  - They may change during COLLECT and are valid only from o_done_pls onward.
  - They hold until the next accepted start's first sample; a start alone does not clear them.
- Latency: o_done_pls asserts one cycle after the clock edge that accepts the last sample. With i_valid continuously high from the cycle after start, done occurs NUM_ELEMS+1 cycles after the start cycle.
- Counter is IDX_W bits and must not wrap before the terminal compare. Terminal detect is counter==NUM_ELEMS-1 with i_valid=1.
- Back-to-back: a start in the cycle after DONE (IDLE) is accepted normally.

Test Plan:
- Max, INT_W=2, FRACT_W=4, N=4:
  - Stimulus: start, then samples 0x10(1.0), 0x38(-0.5), 0x1F(1.9375), 0x20(-2.0) on consecutive cycles.
  - Required response: done 5 cycles after start; o_ext_num=0x1F, o_ext_idx=2.
- Min, same samples:
  - Required response: o_ext_num=0x20 (most negative), o_ext_idx=3.
  - Required response: all-negative set 0x38, 0x3F, 0x30, 0x3F gives min=0x30, idx=2.
- Ties:
  - Max mode, samples 0x08, 0x08, 0x04, 0x08 -> o_ext_num=0x08, o_ext_idx=0.
  - Min mode, samples 0x20, 0x20, 0x00, 0x00 -> o_ext_idx=0.
- Gapped valid plus same-cycle and busy-time events:
  - Stimulus: i_valid toggling 1,0,0,1,1,0,1.
  - Required response: done follows the 4th valid sample by one cycle.
  - Required response: a sample in the start cycle is ignored.
  - Required response: i_start_pls during COLLECT changes neither mode nor count.
- Reset mid-search:
  - Stimulus: rstn=0 after 2 samples.
  - Required response: outputs=0 next cycle, no o_done_pls.
  - Stimulus: a fresh start then 4 samples.
  - Required response: correct result, with indices 0..3 counted from the fresh start.
- Back-to-back searches:
  - Stimulus: start in the cycle after DONE with i_mode flipped.
  - Required response: second search completes with the new mode; o_busy low for exactly one cycle between the searches.
  - Repeat with N=2 to cover the minimum-depth boundary.

Source files
------------

// File: rtl/gen_fip_sign_extremum_finder_if.sv
// Sample-stream / result bundle for gen_fip_sign_extremum_finder.
//   master : drives i_start_pls, i_mode, i_valid and i_num. Reads the results.
//   slave  : the finder. Drives o_busy, o_done_pls, o_ext_num and o_ext_idx.
// W and IDX_W are derived here so that both ends agree on the widths.
interface gen_fip_sign_extremum_finder_if #(
    parameter int INT_W     = 2,
    parameter int FRACT_W   = 4,
    parameter int NUM_ELEMS = 4
);
    localparam int W     = INT_W + FRACT_W;
    localparam int IDX_W = ($clog2(NUM_ELEMS) > 1) ? $clog2(NUM_ELEMS) : 1;

    logic             i_start_pls;
    logic             i_mode;
    logic             i_valid;
    logic [W-1:0]     i_num;
    logic             o_busy;
    logic             o_done_pls;
    logic [W-1:0]     o_ext_num;
    logic [IDX_W-1:0] o_ext_idx;

    modport master (
        output i_start_pls, i_mode, i_valid, i_num,
        input  o_busy, o_done_pls, o_ext_num, o_ext_idx
    );

    modport slave (
        input  i_start_pls, i_mode, i_valid, i_num,
        output o_busy, o_done_pls, o_ext_num, o_ext_idx
    );
endinterface

// File: rtl/gen_fip_sign_extremum_finder.sv
// Streaming signed fixed-point extremum finder.
// A start pulse in IDLE latches the mode (0 = max, 1 = min).
// The block then accepts NUM_ELEMS valid samples and tracks the running extremum and its
// zero-based arrival index. It reports the result with a one-cycle done pulse.
// Ports:
//   clk   : clock
//   rstn  : synchronous active-low reset
//   bus   : slave side of gen_fip_sign_extremum_finder_if
//           (start/mode/valid/num in, busy/done/ext_num/ext_idx out)
module gen_fip_sign_extremum_finder #(
    parameter int INT_W     = 2,
    parameter int FRACT_W   = 4,
    parameter int NUM_ELEMS = 4
) (
    input  logic                           clk,
    input  logic                           rstn,
    gen_fip_sign_extremum_finder_if.slave  bus
);
    localparam int W     = INT_W + FRACT_W;
    localparam int IDX_W = ($clog2(NUM_ELEMS) > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMS - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [W-1:0]     ext_num_q, ext_num_d;
    logic [IDX_W-1:0] ext_idx_q, ext_idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             better;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        ext_num_d = ext_num_q;
        ext_idx_d = ext_idx_q;
        better    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start_pls) begin
                    state_d = COLLECT;
                    mode_d  = bus.i_mode;
                    cnt_d   = '0;
                end
            end
            COLLECT: begin
                if (bus.i_valid) begin
                    // A full-width signed compare orders the most negative code
                    // correctly. A strict compare keeps the earliest index on ties.
                    if (mode_q)
                        better = $signed(bus.i_num) < $signed(ext_num_q);
                    else
                        better = $signed(bus.i_num) > $signed(ext_num_q);
                    if (cnt_q == '0 || better) begin
                        ext_num_d = bus.i_num;
                        ext_idx_d = cnt_q;
                    end
                    // The counter stops at the last index, so it never wraps.
                    if (cnt_q == LAST_IDX)
                        state_d = DONE;
                    else
                        cnt_d = cnt_q + IDX_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Status outputs are registered from the next state, so they line up with it.
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            ext_num_q <= '0;
            ext_idx_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            ext_num_q <= ext_num_d;
            ext_idx_q <= ext_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.o_busy     = busy_q;
    assign bus.o_done_pls = done_q;
    assign bus.o_ext_num  = ext_num_q;
    assign bus.o_ext_idx  = ext_idx_q;
endmodule

// File: tb/tb_gen_fip_sign_extremum_finder.sv
// Self-checking bench for gen_fip_sign_extremum_finder.
// The bench exercises an N=4 instance and an N=2 instance.
// Expected results come from a queue-based reference that finds the best value first,
// then the first index holding it.
module tb_gen_fip_sign_extremum_finder;
    localparam int W = 6;

    logic clk;
    logic rstn;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] smp [4];
    int           gap [4];
    logic [W-1:0] prev_num;
    int           prev_idx;

    gen_fip_sign_extremum_finder_if #(.INT_W(2), .FRACT_W(4), .NUM_ELEMS(4)) bus4 ();
    gen_fip_sign_extremum_finder_if #(.INT_W(2), .FRACT_W(4), .NUM_ELEMS(2)) bus2 ();

    gen_fip_sign_extremum_finder #(.INT_W(2), .FRACT_W(4), .NUM_ELEMS(4)) u_dut4 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus4)
    );

    gen_fip_sign_extremum_finder #(.INT_W(2), .FRACT_W(4), .NUM_ELEMS(2)) u_dut2 (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: the best value is picked over the whole set, then the first index holding it.
    function automatic void ref_ext(input logic mode, input int n,
                                    output logic [W-1:0] en, output int ei);
        int vals[$];
        int best;
        for (int i = 0; i < n; i++) vals.push_back(int'($signed(smp[i])));
        best = vals[0];
        foreach (vals[i]) begin
            if (mode ? (vals[i] < best) : (vals[i] > best)) best = vals[i];
        end
        ei = -1;
        foreach (vals[i]) begin
            if (ei < 0 && vals[i] == best) ei = i;
        end
        en = best[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_smp();
        case ($urandom_range(0, 4))
            0:       return 6'h20;
            1:       return 6'h1F;
            default: return W'($urandom);
        endcase
    endfunction

    // Runs one N=4 search. It starts in an idle cycle and ends in the cycle after done.
    // When noise is set, the bench also sends a sample in the start cycle.
    // It also pulses start with the opposite mode throughout the search.
    task automatic run4(input logic mode, input bit noise);
        logic [W-1:0] en;
        int           ei;
        ref_ext(mode, 4, en, ei);
        check("idle_busy", bus4.o_busy, 0);
        check("idle_done", bus4.o_done_pls, 0);
        bus4.i_start_pls = 1'b1;
        bus4.i_mode      = mode;
        bus4.i_valid     = noise;
        bus4.i_num       = mode ? 6'h20 : 6'h1F;
        step();
        check("start_busy", bus4.o_busy, 1);
        check("hold_num", bus4.o_ext_num, prev_num);
        check("hold_idx", bus4.o_ext_idx, prev_idx);
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < gap[i]; g++) begin
                bus4.i_start_pls = noise;
                bus4.i_mode      = ~mode;
                bus4.i_valid     = 1'b0;
                bus4.i_num       = rnd_smp();
                step();
                check("gap_done", bus4.o_done_pls, 0);
                check("gap_busy", bus4.o_busy, 1);
            end
            bus4.i_start_pls = noise;
            bus4.i_mode      = ~mode;
            bus4.i_valid     = 1'b1;
            bus4.i_num       = smp[i];
            step();
            if (i < 3) begin
                check("early_done", bus4.o_done_pls, 0);
                check("coll_busy", bus4.o_busy, 1);
            end
        end
        bus4.i_start_pls = 1'b0;
        bus4.i_valid     = 1'b0;
        bus4.i_mode      = 1'b0;
        check("done", bus4.o_done_pls, 1);
        check("done_busy", bus4.o_busy, 1);
        check("ext_num", bus4.o_ext_num, en);
        check("ext_idx", bus4.o_ext_idx, ei);
        prev_num = en;
        prev_idx = ei;
        if (bus4.o_done_pls !== 1'b1) begin
            for (int k = 0; k < 20 && bus4.o_busy; k++) step();
        end
        step();
        check("done_width", bus4.o_done_pls, 0);
    endtask

    // Runs one N=2 search with no gaps. It ends in the cycle after done.
    task automatic run2(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] en;
        int           ei;
        smp[0] = a;
        smp[1] = b;
        ref_ext(mode, 2, en, ei);
        check("n2_idle_busy", bus2.o_busy, 0);
        bus2.i_start_pls = 1'b1;
        bus2.i_mode      = mode;
        bus2.i_valid     = 1'b0;
        step();
        check("n2_start_busy", bus2.o_busy, 1);
        bus2.i_start_pls = 1'b0;
        bus2.i_valid     = 1'b1;
        bus2.i_num       = a;
        step();
        check("n2_early_done", bus2.o_done_pls, 0);
        bus2.i_num = b;
        step();
        bus2.i_valid = 1'b0;
        check("n2_done", bus2.o_done_pls, 1);
        check("n2_ext_num", bus2.o_ext_num, en);
        check("n2_ext_idx", bus2.o_ext_idx, ei);
        if (bus2.o_done_pls !== 1'b1) begin
            for (int k = 0; k < 20 && bus2.o_busy; k++) step();
        end
        step();
        check("n2_done_width", bus2.o_done_pls, 0);
    endtask

    task automatic set4(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] c, input logic [W-1:0] d);
        smp[0] = a; smp[1] = b; smp[2] = c; smp[3] = d;
        foreach (gap[i]) gap[i] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        bus4.i_start_pls = 1'b0; bus4.i_mode = 1'b0; bus4.i_valid = 1'b0; bus4.i_num = '0;
        bus2.i_start_pls = 1'b0; bus2.i_mode = 1'b0; bus2.i_valid = 1'b0; bus2.i_num = '0;
        prev_num = '0;
        prev_idx = 0;
        repeat (3) step();
        check("rst_busy", bus4.o_busy, 0);
        check("rst_done", bus4.o_done_pls, 0);
        check("rst_num", bus4.o_ext_num, 0);
        check("rst_idx", bus4.o_ext_idx, 0);
        rstn = 1'b1;
        step();

        // Directed max search, followed back-to-back by a min search over the same samples.
        set4(6'h10, 6'h38, 6'h1F, 6'h20);
        run4(1'b0, 1'b0);
        run4(1'b1, 1'b0);
        set4(6'h38, 6'h3F, 6'h30, 6'h3F);
        run4(1'b1, 1'b0);
        set4(6'h08, 6'h08, 6'h04, 6'h08);
        run4(1'b0, 1'b0);
        set4(6'h20, 6'h20, 6'h00, 6'h00);
        run4(1'b1, 1'b0);

        // Valid pattern 1,0,0,1,1,0,1, with a sample in the start cycle and start pulses during collection.
        set4(6'h05, 6'h1F, 6'h2A, 6'h11);
        gap[1] = 2; gap[3] = 1;
        run4(1'b0, 1'b1);
        run4(1'b1, 1'b1);

        // Reset after two samples: the partial result is dropped and no done pulse follows.
        bus4.i_start_pls = 1'b1; bus4.i_mode = 1'b0;
        step();
        bus4.i_start_pls = 1'b0; bus4.i_valid = 1'b1;
        bus4.i_num = 6'h1F; step();
        bus4.i_num = 6'h1E; step();
        bus4.i_valid = 1'b0;
        rstn = 1'b0;
        step();
        check("mrst_busy", bus4.o_busy, 0);
        check("mrst_done", bus4.o_done_pls, 0);
        check("mrst_num", bus4.o_ext_num, 0);
        check("mrst_idx", bus4.o_ext_idx, 0);
        rstn = 1'b1;
        step();
        check("mrst_nodone", bus4.o_done_pls, 0);
        prev_num = '0;
        prev_idx = 0;
        set4(6'h01, 6'h03, 6'h02, 6'h03);
        run4(1'b0, 1'b0);

        // Random searches with random gaps and noise.
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < 4; i++) begin
                smp[i] = rnd_smp();
                gap[i] = $urandom_range(0, 2);
            end
            if ($urandom_range(0, 3) == 0) smp[2] = smp[0];
            run4(1'(($urandom_range(0, 1))), 1'(($urandom_range(0, 1))));
        end

        // Minimum-depth instance: directed cases, then random back-to-back searches with alternating mode.
        run2(1'b0, 6'h20, 6'h1F);
        run2(1'b1, 6'h20, 6'h1F);
        run2(1'b0, 6'h0A, 6'h0A);
        run2(1'b1, 6'h3F, 6'h3F);
        for (int t = 0; t < 16; t++) begin
            run2(1'(t & 1), rnd_smp(), rnd_smp());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
